// File: rtl/irt_dep_scanner.sv
// Register-use mask table plus a scan FSM that finds the first hoistable entry behind a blocked head.
// One entry is examined per cycle; a result pulses scan_done, and scan_start is ignored while busy.
module irt_dep_scanner #(
   parameter  int BS     = 32,
   parameter  int REGNUM = 16,
   localparam int IW     = $clog2(BS),
   localparam int RW     = $clog2(REGNUM)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic          wr_regwrite,
   input  logic [RW-1:0] wr_rd,
   input  logic [RW-1:0] wr_rs1,
   input  logic [RW-1:0] wr_rs2,
   input  logic          clr_en,
   input  logic [IW-1:0] clr_idx,
   input  logic          scan_start,
   input  logic [IW-1:0] scan_head,
   input  logic [IW:0]   scan_count,
   output logic          scan_busy,
   output logic          scan_done,
   output logic          scan_found,
   output logic [IW-1:0] scan_idx
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam logic [IW:0] BS_W = (IW+1)'(BS);

   logic              valid   [BS];
   logic [REGNUM-1:0] rd_mask [BS];
   logic [REGNUM-1:0] rs_mask [BS];

   state_t            state, state_nxt;
   logic [IW-1:0]     ptr, ptr_nxt;
   logic [IW-1:0]     rem, rem_nxt;
   logic [REGNUM-1:0] acc_rd, acc_rd_nxt;
   logic [REGNUM-1:0] acc_rs, acc_rs_nxt;
   logic              found, found_nxt;
   logic [IW-1:0]     idx, idx_nxt;

   logic [IW:0]       n_clamp;
   logic [IW:0]       n_minus1;
   logic              cur_valid;
   logic [REGNUM-1:0] cur_rd;
   logic [REGNUM-1:0] cur_rs;
   logic              cur_indep;

   // x0 maps to an empty mask so it never creates a dependency
   function automatic logic [REGNUM-1:0] reg_bit(input logic [RW-1:0] r);
      logic [REGNUM-1:0] m;
      m = '0;
      if (r != '0)
         m[r] = 1'b1;
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BS; i++) begin
            valid[i]   <= 1'b0;
            rd_mask[i] <= '0;
            rs_mask[i] <= '0;
         end
      end else begin
         if (clr_en)
            valid[clr_idx] <= 1'b0;
         // Later assignment lets a same-index write override the clear
         if (wr_en) begin
            valid[wr_idx]   <= 1'b1;
            rd_mask[wr_idx] <= wr_regwrite ? reg_bit(wr_rd) : '0;
            rs_mask[wr_idx] <= reg_bit(wr_rs1) | reg_bit(wr_rs2);
         end
      end
   end

   assign n_clamp   = (scan_count > BS_W) ? BS_W : scan_count;
   assign n_minus1  = n_clamp - 1'b1;
   assign cur_valid = valid[ptr];
   assign cur_rd    = rd_mask[ptr];
   assign cur_rs    = rs_mask[ptr];
   assign cur_indep = ((cur_rs & acc_rd) == '0) && ((cur_rd & acc_rs) == '0) &&
                      ((cur_rd & acc_rd) == '0);

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      rem_nxt    = rem;
      acc_rd_nxt = acc_rd;
      acc_rs_nxt = acc_rs;
      found_nxt  = found;
      idx_nxt    = idx;
      case (state)
         S_IDLE: begin
            if (scan_start) begin
               state_nxt  = S_SCAN;
               ptr_nxt    = scan_head + 1'b1;
               rem_nxt    = (n_clamp == '0) ? '0 : n_minus1[IW-1:0];
               acc_rd_nxt = valid[scan_head] ? rd_mask[scan_head] : '0;
               acc_rs_nxt = valid[scan_head] ? rs_mask[scan_head] : '0;
               found_nxt  = 1'b0;
               idx_nxt    = '0;
            end
         end
         S_SCAN: begin
            if (rem == '0) begin
               state_nxt = S_DONE;
               found_nxt = 1'b0;
               idx_nxt   = '0;
            end else if (cur_valid && cur_indep) begin
               state_nxt = S_DONE;
               found_nxt = 1'b1;
               idx_nxt   = ptr;
            end else begin
               if (cur_valid) begin
                  acc_rd_nxt = acc_rd | cur_rd;
                  acc_rs_nxt = acc_rs | cur_rs;
               end
               ptr_nxt = ptr + 1'b1;
               rem_nxt = rem - 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         ptr    <= '0;
         rem    <= '0;
         acc_rd <= '0;
         acc_rs <= '0;
         found  <= 1'b0;
         idx    <= '0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         rem    <= rem_nxt;
         acc_rd <= acc_rd_nxt;
         acc_rs <= acc_rs_nxt;
         found  <= found_nxt;
         idx    <= idx_nxt;
      end
   end

   assign scan_busy  = (state != S_IDLE);
   assign scan_done  = (state == S_DONE);
   assign scan_found = found;
   assign scan_idx   = idx;

endmodule
